truth_table_scanner: RTL and testbench

Sequencer that exhaustively exercises a combinational N-input boolean block such as the 3-input SoP(2,5,6,7) function unit. On a start request it drives every input combination in ascending binary order and waits a programmable settle time per point. It samples the block's output into a truth-table register and compares the result against an expected minterm mask. It replaces hand-written stimulus loops with a reusable on-chip self-check controller.

---
 rtl/truth_table_scanner_if.sv | 25 ++
 rtl/truth_table_scanner.sv | 124 ++++++++++++
 tb/tb_truth_table_scanner.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_scanner_if.sv
// Bundles the start/result handshake and the stimulus/response pair between
// the scanner (master) and whoever requests scans and hosts the block (slave).
interface truth_table_scanner_if #(
    parameter int N_VARS = 3
);
    logic                     start;
    logic                     s_in;
    logic [N_VARS-1:0]        sel;
    logic                     busy;
    logic                     done;
    logic [(2**N_VARS)-1:0]   table_q;
    logic                     match;
    logic [N_VARS:0]          mismatch_count;
    logic [N_VARS-1:0]        first_mismatch;

    modport master (
        input  start, s_in,
        output sel, busy, done, table_q, match, mismatch_count, first_mismatch
    );

    modport slave (
        output start, s_in,
        input  sel, busy, done, table_q, match, mismatch_count, first_mismatch
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks every input combination of an N-input combinational block, captures its
// truth table and grades it against an expected minterm mask.
module truth_table_scanner #(
    parameter int                        N_VARS   = 3,
    parameter int                        SETTLE   = 1,
    parameter logic [(2**N_VARS)-1:0]    EXPECTED = 8'hE4
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_scanner_if.master bus
);
    localparam int                WIDTH       = 2**N_VARS;
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_VARS-1:0] IDX_LAST    = {N_VARS{1'b1}};
    localparam logic [N_VARS-1:0] IDX_ONE     = {{(N_VARS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t              state, state_next;
    logic [N_VARS-1:0]   idx, idx_next;
    logic [3:0]          settle_cnt, cnt_next;
    logic [WIDTH-1:0]    table_q, table_next;
    logic                clear_results, load_results;
    logic                match_q;
    logic [N_VARS:0]     mismatch_count_q, count_calc;
    logic [N_VARS-1:0]   first_mismatch_q, first_calc;
    logic [WIDTH-1:0]    diff;

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        cnt_next      = settle_cnt;
        table_next    = table_q;
        clear_results = 1'b0;
        load_results  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    table_next    = '0;
                    clear_results = 1'b1;
                    idx_next      = '0;
                    cnt_next      = '0;
                    state_next    = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    cnt_next   = '0;
                    state_next = SAMPLE;
                end else begin
                    cnt_next = settle_cnt + 4'd1;
                end
            end
            SAMPLE: begin
                table_next[idx] = bus.s_in;
                if (idx == IDX_LAST) begin
                    load_results = 1'b1;
                    state_next   = DONE;
                end else begin
                    idx_next   = idx + IDX_ONE;
                    state_next = DRIVE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grading looks at the table as it will be after this edge, so the
    // verdict lands in the same cycle the DONE state is entered.
    always_comb begin
        diff       = table_next ^ EXPECTED;
        count_calc = '0;
        first_calc = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (diff[i]) first_calc = i[N_VARS-1:0];
            count_calc = count_calc + {{N_VARS{1'b0}}, diff[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            settle_cnt       <= '0;
            table_q          <= '0;
            match_q          <= 1'b0;
            mismatch_count_q <= '0;
            first_mismatch_q <= '0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            settle_cnt <= cnt_next;
            table_q    <= table_next;
            if (clear_results) begin
                match_q          <= 1'b0;
                mismatch_count_q <= '0;
                first_mismatch_q <= '0;
            end else if (load_results) begin
                match_q          <= (table_next == EXPECTED);
                mismatch_count_q <= count_calc;
                first_mismatch_q <= first_calc;
            end
        end
    end

    // sel is simply the scan index, which holds its last value while idle.
    assign bus.sel            = idx;
    assign bus.busy           = (state != IDLE);
    assign bus.done           = (state == DONE);
    assign bus.table_q        = table_q;
    assign bus.match          = match_q;
    assign bus.mismatch_count = mismatch_count_q;
    assign bus.first_mismatch = first_mismatch_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Drives two scanner builds (SETTLE=1 and SETTLE=3) and compares every cycle
// against a cycle-arithmetic model of the scan schedule and its grading.
module tb_truth_table_scanner;
    localparam int         N   = 3;
    localparam int         W   = 8;
    localparam logic [7:0] EXP = 8'hE4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;

    truth_table_scanner_if #(.N_VARS(N)) if0 ();
    truth_table_scanner_if #(.N_VARS(N)) if1 ();

    truth_table_scanner #(.N_VARS(N), .SETTLE(1), .EXPECTED(EXP)) dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (if0)
    );

    truth_table_scanner #(.N_VARS(N), .SETTLE(3), .EXPECTED(EXP)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1)
    );

    int total = 0;
    int bad   = 0;
    int gcyc  = 0;

    int         settle_of [2] = '{1, 3};
    int         m_acc     [2];
    logic [7:0] m_tab     [2];
    logic [2:0] m_sel     [2];
    logic       m_match   [2];
    int         m_cnt     [2];
    int         m_first   [2];

    bit st_sch [0:63];
    bit rs_sch [0:63];

    task automatic check_output(input string tag, input int cyc,
                                input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) begin
            st_sch[i] = 1'b0;
            rs_sch[i] = 1'b0;
        end
    endtask

    task automatic model_reset(input int d);
        m_acc[d]   = -1;
        m_tab[d]   = '0;
        m_sel[d]   = '0;
        m_match[d] = 1'b0;
        m_cnt[d]   = 0;
        m_first[d] = 0;
    endtask

    // Grading straight from the definition: positions that disagree with EXP.
    task automatic model_grade(input int d);
        logic [7:0] diff;
        diff       = m_tab[d] ^ EXP;
        m_match[d] = (diff == 8'h00);
        m_cnt[d]   = 0;
        m_first[d] = 0;
        for (int i = 0; i < W; i++) begin
            if (diff[i]) m_cnt[d]++;
        end
        for (int i = W - 1; i >= 0; i--) begin
            if (diff[i]) m_first[d] = i;
        end
    endtask

    task automatic drive_dut(input int d, input logic st, input logic rs, input logic si);
        if (d == 0) begin
            if0.start = st;
            rst0      = rs;
            if0.s_in  = si;
        end else begin
            if1.start = st;
            rst1      = rs;
            if1.s_in  = si;
        end
    endtask

    task automatic read_dut(input int d, output logic [2:0] sel, output logic busy,
                            output logic done, output logic [7:0] tq, output logic match,
                            output logic [3:0] cnt, output logic [2:0] first);
        if (d == 0) begin
            sel = if0.sel; busy = if0.busy; done = if0.done; tq = if0.table_q;
            match = if0.match; cnt = if0.mismatch_count; first = if0.first_mismatch;
        end else begin
            sel = if1.sel; busy = if1.busy; done = if1.done; tq = if1.table_q;
            match = if1.match; cnt = if1.mismatch_count; first = if1.first_mismatch;
        end
    endtask

    // One call covers ncyc clock cycles on DUT d; cycle c of the call is the
    // interval just before its c-th edge, where st_sch/rs_sch[c] are sampled.
    task automatic apply_stimulus(input int d, input int ncyc, input logic [7:0] blk,
                                  input bit glitch);
        for (int c = 0; c < ncyc; c++) begin
            int         s, t, k, i;
            bit         busy_e, done_e, samp;
            logic       sin;
            logic [2:0] o_sel, o_first;
            logic       o_busy, o_done, o_match;
            logic [7:0] o_tq;
            logic [3:0] o_cnt;

            s      = settle_of[d];
            t      = 1 + W * (s + 1);
            k      = gcyc - m_acc[d];
            busy_e = (m_acc[d] >= 0) && (k >= 1) && (k <= t);
            done_e = busy_e && (k == t);
            samp   = busy_e && (k < t) && (((k - 1) % (s + 1)) == s);
            i      = 0;
            if (busy_e && (k < t)) begin
                i        = (k - 1) / (s + 1);
                m_sel[d] = i[2:0];
            end

            read_dut(d, o_sel, o_busy, o_done, o_tq, o_match, o_cnt, o_first);
            check_output("sel",            c, 32'(o_sel),   32'(m_sel[d]));
            check_output("busy",           c, 32'(o_busy),  32'(busy_e));
            check_output("done",           c, 32'(o_done),  32'(done_e));
            check_output("table_q",        c, 32'(o_tq),    32'(m_tab[d]));
            check_output("match",          c, 32'(o_match), 32'(m_match[d]));
            check_output("mismatch_count", c, 32'(o_cnt),   32'(m_cnt[d]));
            check_output("first_mismatch", c, 32'(o_first), 32'(m_first[d]));

            sin = (glitch && !samp) ? 1'($urandom) : blk[o_sel];
            drive_dut(d, st_sch[c], rs_sch[c], sin);
            @(posedge clk);
            #1;

            if (rs_sch[c]) begin
                model_reset(d);
            end else if (!busy_e && st_sch[c]) begin
                model_reset(d);
                m_acc[d] = gcyc;
            end else if (samp) begin
                m_tab[d][i] = sin;
                if (i == W - 1) model_grade(d);
            end
            gcyc++;
        end
        drive_dut(d, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        drive_dut(0, 1'b0, 1'b1, 1'b0);
        drive_dut(1, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_reset(0);
        model_reset(1);
        clear_sched();

        $display("[TB] reset state");
        apply_stimulus(0, 2, EXP, 1'b0);
        apply_stimulus(1, 2, EXP, 1'b0);

        $display("[TB] correct SoP(2,5,6,7) block");
        clear_sched(); st_sch[0] = 1'b1;
        apply_stimulus(0, 20, 8'hE4, 1'b0);

        $display("[TB] faulty block at combination 3");
        clear_sched(); st_sch[0] = 1'b1;
        apply_stimulus(0, 20, 8'hEC, 1'b0);

        $display("[TB] stuck-at-0 block");
        clear_sched(); st_sch[0] = 1'b1;
        apply_stimulus(0, 20, 8'h00, 1'b0);

        $display("[TB] SETTLE=3 build");
        clear_sched(); st_sch[0] = 1'b1;
        apply_stimulus(1, 36, 8'hE4, 1'b0);

        $display("[TB] reset mid-scan then restart");
        clear_sched(); st_sch[0] = 1'b1; rs_sch[7] = 1'b1; st_sch[10] = 1'b1;
        apply_stimulus(0, 30, 8'hE4, 1'b0);

        $display("[TB] start while busy, then held high");
        clear_sched(); st_sch[0] = 1'b1; st_sch[5] = 1'b1; st_sch[17] = 1'b1;
        for (int c = 18; c <= 35; c++) st_sch[c] = 1'b1;
        apply_stimulus(0, 38, 8'hE4, 1'b0);

        $display("[TB] random blocks with glitches outside sampling");
        for (int n = 0; n < 6; n++) begin
            int         d;
            logic [7:0] blk;
            d   = int'($urandom_range(0, 1));
            blk = 8'($urandom);
            clear_sched(); st_sch[0] = 1'b1;
            apply_stimulus(d, 36, blk, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
